// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// EX-stage forwarding selects for NUM_SRC operands, load-use / issue-use /
// pending-use / structural hazard detection, and a one-entry scoreboard for
// a single outstanding variable-latency (mul/div) operation.
// Optional build macro: HAZARD_WAW_CHECK_EN adds a destination (WAW) check
// against the pending long-op register.
module hazard_scoreboard_unit #(
    parameter int  REG_AW  = 5,
    parameter int  NUM_SRC = 2,
    parameter int  MAX_LAT = 32,
    localparam int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] src_D,
    input  logic [NUM_SRC-1:0]        src_valid_D,
    input  logic [REG_AW-1:0]         write_reg_D,
    input  logic                      reg_write_D,
    input  logic                      long_D,
    input  logic [NUM_SRC*REG_AW-1:0] src_E,
    input  logic [REG_AW-1:0]         write_reg_E,
    input  logic                      reg_write_E,
    input  logic                      mem_to_reg_E,
    input  logic                      long_issue_E,
    input  logic [LW-1:0]             long_lat_E,
    input  logic [REG_AW-1:0]         write_reg_M,
    input  logic                      reg_write_M,
    input  logic [REG_AW-1:0]         write_reg_W,
    input  logic                      reg_write_W,
    output logic [2*NUM_SRC-1:0]      forward_E,
    output logic                      stall_F,
    output logic                      stall_D,
    output logic                      flush_E,
    output logic                      long_wb,
    output logic                      long_busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [REG_AW-1:0] pend_q, pend_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lat_m1;
    logic              load_use, issue_use, pending_use, structural, waw_hazard;

    // True when any actually-read ID operand names non-zero register r
    function automatic logic id_match(input logic [REG_AW-1:0] r);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_valid_D[i] && (r != '0) && (src_D[i*REG_AW +: REG_AW] == r))
                hit = 1'b1;
        end
        return hit;
    endfunction

    // Per-operand forwarding select, MEM has priority over WB, r0 never forwarded
    always_comb begin
        logic [REG_AW-1:0] s;
        forward_E = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            s = src_E[i*REG_AW +: REG_AW];
            if (reg_write_M && (write_reg_M != '0) && (write_reg_M == s))
                forward_E[2*i +: 2] = 2'b10;
            else if (reg_write_W && (write_reg_W != '0) && (write_reg_W == s))
                forward_E[2*i +: 2] = 2'b01;
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scoreboard next state; a latency of 0 is treated as 1
    always_comb begin
        lat_m1  = (long_lat_E == '0) ? '0 : long_lat_E - 1'b1;
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (long_issue_E) begin
                    pend_d  = write_reg_E;
                    cnt_d   = lat_m1;
                    state_d = (lat_m1 == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LW'(1))
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                pend_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HAZARD_WAW_CHECK_EN
    // Younger short op must not write the register the long op will overwrite
    always_comb begin
        waw_hazard = reg_write_D && (write_reg_D != '0) && (state_q != IDLE) &&
                     (write_reg_D == pend_q);
    end
`else
    logic unused_waw;
    // No destination check in this build
    always_comb begin
        waw_hazard = 1'b0;
        unused_waw = ^{write_reg_D, reg_write_D};
    end
`endif

    // Hazard detection and scoreboard status outputs
    always_comb begin
        long_busy   = (state_q != IDLE);
        long_wb     = (state_q == DONE);
        load_use    = reg_write_E && mem_to_reg_E && id_match(write_reg_E);
        issue_use   = long_issue_E && reg_write_E && id_match(write_reg_E);
        pending_use = (state_q != IDLE) && id_match(pend_q);
        structural  = long_D && (state_q != IDLE);
        stall_F     = load_use || issue_use || pending_use || structural || waw_hazard;
        stall_D     = stall_F;
        flush_E     = stall_F;
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed scenarios plus a
// randomized run checked against a cycle-numbered reference model.
module tb_hazard_scoreboard_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int MAX_LAT = 32;
    localparam int LW      = $clog2(MAX_LAT + 1);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC*REG_AW-1:0] src_D;
    logic [NUM_SRC-1:0]        src_valid_D;
    logic [REG_AW-1:0]         write_reg_D;
    logic                      reg_write_D;
    logic                      long_D;
    logic [NUM_SRC*REG_AW-1:0] src_E;
    logic [REG_AW-1:0]         write_reg_E;
    logic                      reg_write_E;
    logic                      mem_to_reg_E;
    logic                      long_issue_E;
    logic [LW-1:0]             long_lat_E;
    logic [REG_AW-1:0]         write_reg_M;
    logic                      reg_write_M;
    logic [REG_AW-1:0]         write_reg_W;
    logic                      reg_write_W;
    logic [2*NUM_SRC-1:0]      forward_E;
    logic                      stall_F, stall_D, flush_E, long_wb, long_busy;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT)) dut (
        .clk(clk), .rst(rst),
        .src_D(src_D), .src_valid_D(src_valid_D),
        .write_reg_D(write_reg_D), .reg_write_D(reg_write_D), .long_D(long_D),
        .src_E(src_E), .write_reg_E(write_reg_E), .reg_write_E(reg_write_E),
        .mem_to_reg_E(mem_to_reg_E), .long_issue_E(long_issue_E), .long_lat_E(long_lat_E),
        .write_reg_M(write_reg_M), .reg_write_M(reg_write_M),
        .write_reg_W(write_reg_W), .reg_write_W(reg_write_W),
        .forward_E(forward_E), .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
        .long_wb(long_wb), .long_busy(long_busy)
    );

    always #5 clk = ~clk;

    // Reference model: the long op is described by the cycle number of its
    // write-back; it is pending in every cycle after issue up to and including it.
    int                cyc     = 0;
    int                m_done  = 0;
    logic              m_valid = 1'b0;
    logic [REG_AW-1:0] m_pend  = '0;

    function automatic logic m_busy();
        return m_valid && (cyc <= m_done);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
        end else if (!m_busy() && long_issue_E) begin
            m_valid = 1'b1;
            m_pend  = write_reg_E;
            m_done  = cyc + ((long_lat_E == 0) ? 1 : int'(long_lat_E));
        end
        cyc = cyc + 1;
    end

    function automatic logic [2*NUM_SRC-1:0] exp_fwd();
        logic [2*NUM_SRC-1:0] f;
        logic [REG_AW-1:0]    s;
        f = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = src_E[i*REG_AW +: REG_AW];
            if (reg_write_M && write_reg_M != 0 && write_reg_M == s)      f[2*i +: 2] = 2'b10;
            else if (reg_write_W && write_reg_W != 0 && write_reg_W == s) f[2*i +: 2] = 2'b01;
        end
        return f;
    endfunction

    function automatic logic exp_stall();
        logic              h;
        logic [REG_AW-1:0] s;
        h = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = src_D[i*REG_AW +: REG_AW];
            if (src_valid_D[i] && s != 0) begin
                if (reg_write_E && s == write_reg_E && (mem_to_reg_E || long_issue_E)) h = 1'b1;
                if (m_busy() && s == m_pend) h = 1'b1;
            end
        end
        if (long_D && m_busy()) h = 1'b1;
`ifdef HAZARD_WAW_CHECK_EN
        if (reg_write_D && write_reg_D != 0 && m_busy() && write_reg_D == m_pend) h = 1'b1;
`endif
        return h;
    endfunction

    task automatic clr();
        rst = 1'b0; src_D = '0; src_valid_D = '0; write_reg_D = '0; reg_write_D = 1'b0;
        long_D = 1'b0; src_E = '0; write_reg_E = '0; reg_write_E = 1'b0; mem_to_reg_E = 1'b0;
        long_issue_E = 1'b0; long_lat_E = '0; write_reg_M = '0; reg_write_M = 1'b0;
        write_reg_W = '0; reg_write_W = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #2;
        n_checks++;
        if (long_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", long_busy); end
        n_checks++;
        if (long_wb !== 1'b0) begin n_fail++; $display("FAIL reset_wb: got %b expected 0", long_wb); end
        n_checks++;
        if ({stall_F, stall_D, flush_E} !== 3'b000) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 000", {stall_F, stall_D, flush_E});
        end
        n_checks++;
        if (forward_E !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd: got %b expected 0000", forward_E); end
    endtask

    task automatic test_forwarding();
        logic [3:0] exp;
        clr(); tick();
        // M and W both hold r3, operand 0 reads r3: MEM wins
        write_reg_M = 5'd3; reg_write_M = 1'b1; write_reg_W = 5'd3; reg_write_W = 1'b1;
        src_E = {5'd9, 5'd3};
        #2; exp = 4'b0010; n_checks++;
        if (forward_E !== exp) begin n_fail++; $display("FAIL fwd_mem_prio: got %b expected %b", forward_E, exp); end
        tick(); write_reg_M = 5'd0;
        #2; exp = 4'b0001; n_checks++;
        if (forward_E !== exp) begin n_fail++; $display("FAIL fwd_wb: got %b expected %b", forward_E, exp); end
        tick(); src_E = {5'd9, 5'd0};
        #2; exp = 4'b0000; n_checks++;
        if (forward_E !== exp) begin n_fail++; $display("FAIL fwd_r0: got %b expected %b", forward_E, exp); end
        // Operand 1 from MEM, operand 0 from WB simultaneously
        tick(); write_reg_M = 5'd12; reg_write_M = 1'b1; write_reg_W = 5'd4; src_E = {5'd12, 5'd4};
        #2; exp = 4'b1001; n_checks++;
        if (forward_E !== exp) begin n_fail++; $display("FAIL fwd_both_ops: got %b expected %b", forward_E, exp); end
        // Matching address but write enable off
        tick(); reg_write_M = 1'b0; reg_write_W = 1'b0;
        #2; exp = 4'b0000; n_checks++;
        if (forward_E !== exp) begin n_fail++; $display("FAIL fwd_no_we: got %b expected %b", forward_E, exp); end
    endtask

    task automatic test_load_use();
        clr(); tick();
        reg_write_E = 1'b1; mem_to_reg_E = 1'b1; write_reg_E = 5'd5;
        src_D = {5'd5, 5'd2}; src_valid_D = 2'b10;
        #2; n_checks++;
        if ({stall_F, stall_D, flush_E} !== 3'b111) begin
            n_fail++; $display("FAIL load_use_stall: got %b expected 111", {stall_F, stall_D, flush_E});
        end
        // Load moves to MEM, ID held: stall must drop
        tick(); reg_write_E = 1'b0; mem_to_reg_E = 1'b0; write_reg_E = '0;
        write_reg_M = 5'd5; reg_write_M = 1'b1;
        #2; n_checks++;
        if (stall_F !== 1'b0) begin n_fail++; $display("FAIL load_use_one_cycle: got %b expected 0", stall_F); end
        // Same load but the operand is not actually read
        tick(); clr(); reg_write_E = 1'b1; mem_to_reg_E = 1'b1; write_reg_E = 5'd5;
        src_D = {5'd5, 5'd2}; src_valid_D = 2'b00;
        #2; n_checks++;
        if (stall_F !== 1'b0) begin n_fail++; $display("FAIL load_use_invalid_src: got %b expected 0", stall_F); end
    endtask

    task automatic test_long_op();
        logic es, ew, eb;
        clr(); tick();
        long_issue_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd7; long_lat_E = 6'd4;
        src_D = {5'd0, 5'd7}; src_valid_D = 2'b01;
        for (int k = 0; k <= 5; k++) begin
            #2;
            es = (k <= 4); ew = (k == 4); eb = (k >= 1 && k <= 4);
            n_checks++;
            if ({stall_F, stall_D, flush_E} !== {3{es}}) begin
                n_fail++; $display("FAIL long_stall_t%0d: got %b expected %b", k, {stall_F, stall_D, flush_E}, {3{es}});
            end
            n_checks++;
            if (long_wb !== ew) begin n_fail++; $display("FAIL long_wb_t%0d: got %b expected %b", k, long_wb, ew); end
            n_checks++;
            if (long_busy !== eb) begin n_fail++; $display("FAIL long_busy_t%0d: got %b expected %b", k, long_busy, eb); end
            tick();
            long_issue_E = 1'b0; reg_write_E = 1'b0;
        end
    endtask

    task automatic test_lat_zero_one();
        for (int lat = 0; lat <= 1; lat++) begin
            clr(); tick();
            long_issue_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd9; long_lat_E = LW'(lat);
            tick(); clr(); #2;
            n_checks++;
            if ({long_wb, long_busy} !== 2'b11) begin
                n_fail++; $display("FAIL lat%0d_done_t1: got %b expected 11", lat, {long_wb, long_busy});
            end
            tick(); #2;
            n_checks++;
            if ({long_wb, long_busy} !== 2'b00) begin
                n_fail++; $display("FAIL lat%0d_idle_t2: got %b expected 00", lat, {long_wb, long_busy});
            end
        end
    endtask

    task automatic test_structural();
        logic es;
        clr(); tick();
        long_issue_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd11; long_lat_E = 6'd5;
        for (int k = 0; k <= 6; k++) begin
            #2;
            es = (k >= 1 && k <= 5);
            n_checks++;
            if (stall_D !== es) begin n_fail++; $display("FAIL struct_stall_t%0d: got %b expected %b", k, stall_D, es); end
            tick();
            long_issue_E = 1'b0; reg_write_E = 1'b0; long_D = 1'b1;
        end
        clr();
    endtask

    task automatic test_reset_mid_busy();
        clr(); tick();
        long_issue_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd7; long_lat_E = 6'd6;
        tick(); long_issue_E = 1'b0; reg_write_E = 1'b0;
        src_D = {5'd7, 5'd0}; src_valid_D = 2'b10;
        tick(); tick();
        // Counter now holds 3; assert reset for one cycle
        rst = 1'b1;
        #2; n_checks++;
        if ({long_busy, stall_F} !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_pre: got %b expected 11", {long_busy, stall_F});
        end
        tick(); rst = 1'b0;
        #2; n_checks++;
        if ({long_busy, long_wb, stall_F} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_post: got %b expected 000", {long_busy, long_wb, stall_F});
        end
    endtask

    task automatic test_waw();
        logic es;
        clr(); tick();
        long_issue_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd7; long_lat_E = 6'd4;
        tick(); clr();
        reg_write_D = 1'b1; write_reg_D = 5'd7;
`ifdef HAZARD_WAW_CHECK_EN
        es = 1'b1;
`else
        es = 1'b0;
`endif
        #2; n_checks++;
        if (stall_F !== es) begin n_fail++; $display("FAIL waw_stall: got %b expected %b", stall_F, es); end
        for (int k = 0; k < 4; k++) tick();
        clr();
    endtask

    task automatic test_random();
        logic [3:0] ef;
        logic       es;
        for (int n = 0; n < 600; n++) begin
            tick();
            rst          = ($urandom_range(0, 59) == 0);
            src_D        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_valid_D  = 2'($urandom);
            write_reg_D  = 5'($urandom_range(0, 7));
            reg_write_D  = 1'($urandom);
            long_D       = ($urandom_range(0, 3) == 0);
            src_E        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            write_reg_E  = 5'($urandom_range(0, 7));
            reg_write_E  = 1'($urandom);
            mem_to_reg_E = ($urandom_range(0, 3) == 0);
            long_issue_E = ($urandom_range(0, 4) == 0);
            long_lat_E   = LW'($urandom_range(0, 7));
            write_reg_M  = 5'($urandom_range(0, 7));
            reg_write_M  = 1'($urandom);
            write_reg_W  = 5'($urandom_range(0, 7));
            reg_write_W  = 1'($urandom);
            #2;
            ef = exp_fwd();
            es = exp_stall();
            n_checks++;
            if (forward_E !== ef) begin n_fail++; $display("FAIL rnd_fwd c%0d: got %b expected %b", cyc, forward_E, ef); end
            n_checks++;
            if ({stall_F, stall_D, flush_E} !== {3{es}}) begin
                n_fail++; $display("FAIL rnd_stall c%0d: got %b expected %b", cyc, {stall_F, stall_D, flush_E}, {3{es}});
            end
            n_checks++;
            if (long_busy !== m_busy()) begin
                n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", cyc, long_busy, m_busy());
            end
            n_checks++;
            if (long_wb !== (m_valid && cyc == m_done)) begin
                n_fail++; $display("FAIL rnd_wb c%0d: got %b expected %b", cyc, long_wb, (m_valid && cyc == m_done));
            end
        end
        clr();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_long_op();
        test_lat_zero_one();
        test_structural();
        test_reset_mid_busy();
        test_waw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard and forwarding unit for the 5-stage pipeline, replacing the fixed two-operand combinational forwarding logic. It generates EX-stage forwarding selects for any number of source operands. It detects load-use hazards. It tracks one outstanding variable-latency operation (mul/div) with a registered scoreboard, stalling dependent instructions in ID until that operation writes back.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction
- MAX_LAT, 32, largest long-op latency in cycles; LW = $clog2(MAX_LAT+1)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- src_D  input  NUM_SRC*REG_AW  ID source registers; operand i at bits [i*REG_AW +: REG_AW]
- src_valid_D  input  NUM_SRC  operand i is actually read in ID
- write_reg_D, reg_write_D  input  REG_AW, 1  ID destination (used only with WAW check)
- long_D  input  1  ID instruction is a long-latency op
- src_E  input  NUM_SRC*REG_AW  EX source registers
- write_reg_E, reg_write_E, mem_to_reg_E  input  REG_AW, 1, 1  EX destination, write enable, load flag
- long_issue_E  input  1  EX instruction is a long op starting this cycle
- long_lat_E  input  LW  its latency in cycles
- write_reg_M, reg_write_M, write_reg_W, reg_write_W  input  REG_AW, 1, REG_AW, 1  MEM/WB destinations
- forward_E  output  2*NUM_SRC  per-operand mux select, operand i at [2i+1:2i]
- stall_F, stall_D  output  1  hold PC and IF/ID
- flush_E  output  1  insert bubble into ID/EX
- long_wb  output  1  long-op result occupies the WB port this cycle
- long_busy  output  1  scoreboard holds a pending destination

## Operation
- Forwarding is combinational, per operand i. 10 when reg_write_M && write_reg_M!=0 && write_reg_M==src_E[i]. Else 01 for the same test on W. Else 00. MEM has priority. Register 0 is never forwarded.
- Match(r) for an ID operand is src_valid_D[i] && r!=0 && src_D[i]==r.
- Load-use: reg_write_E && mem_to_reg_E && Match(write_reg_E) for any i.
- Issue-use: long_issue_E && reg_write_E && Match(write_reg_E).
- Pending-use: state!=IDLE && Match(pend_reg).
- Structural: long_D && state!=IDLE.
- Any of these hazards asserts stall_F=stall_D=flush_E=1 in the same cycle.
- FSM states are IDLE, BUSY and DONE. Registered state is pend_reg[REG_AW] and cnt[LW].
  - IDLE to BUSY on long_issue_E: pend_reg<=write_reg_E and cnt<=max(long_lat_E,1)-1. If that value is 0, go to DONE instead.
  - In BUSY, cnt decrements each cycle. When cnt==1, the next state is DONE.
  - In DONE, long_wb=1. Next state is IDLE and pend_reg<=0.
- long_busy = (state!=IDLE).
- long_issue_E while state!=IDLE is a protocol violation. It is ignored and the scoreboard is unchanged.
- rst in any state: state<=IDLE, pend_reg<=0, cnt<=0.

## Timing
- Reset values: long_busy=0 and long_wb=0. Stall and flush are 0 unless the current combinational inputs create a hazard. forward_E is purely combinational.
- Long op issued at cycle t with latency L≥1:
  - BUSY occupies cycles t+1..t+L-1.
  - DONE occurs at t+L, with long_wb=1.
  - IDLE from t+L+1.
- L=0 behaves as L=1.
- A dependent ID instruction stalls through cycle t+L inclusive and proceeds at t+L+1. It reads the register file, which is write-first.
- Load-use stall lasts exactly 1 cycle per occurrence. On the next cycle the load is in MEM and no longer matches the load-use test.
- Simultaneous hazards are OR-ed. The stall holds while any one condition persists.

## Configuration
- HAZARD_WAW_CHECK_EN defined: a WAW hazard is added, reg_write_D && write_reg_D!=0 && state!=IDLE && write_reg_D==pend_reg. It stalls like the other hazards. This prevents a younger short op's write from being overwritten by the long result.
- HAZARD_WAW_CHECK_EN undefined: no destination check. write_reg_D and reg_write_D are unused.

## Test plan
- write_reg_M=3 with reg_write_M, write_reg_W=3 with reg_write_W, src_E[0]=3 -> forward_E[1:0]=10. Set write_reg_M=0 -> 01. Set src_E[0]=0 -> 00.
- EX load with write_reg_E=5, ID src_D[1]=5 valid -> stall_F/stall_D/flush_E=1 for exactly 1 cycle. The same case with src_valid_D[1]=0 -> no stall.
- long_issue_E with write_reg_E=7, long_lat_E=4 at t; ID reads r7 -> stall in t..t+4, long_wb=1 only at t+4, long_busy 0 at t+5, no stall at t+5.
- long_lat_E=0 and long_lat_E=1 -> DONE at t+1 in both cases. long_D during BUSY -> stall until IDLE.
- rst asserted mid-BUSY (cnt=3) -> next cycle long_busy=0, long_wb=0, stall clear.
- With HAZARD_WAW_CHECK_EN, ID writes r7 while r7 is pending -> stall. Without the macro -> no stall.
